// File: rtl/button_counter_display.sv
// Button-driven up/down counter with hold-to-repeat and a
// 4-digit multiplexed seven-segment hex display driver.
module button_counter_display #(
    parameter int WIDTH        = 16,
    parameter int SATURATE     = 0,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int REFRESH_DIV  = 100000
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             btn_clear,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             limit_hit,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                              REPEAT_DELAY : REPEAT_RATE;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

    state_t          state;
    logic [HW-1:0]   hold;
    logic            dir_dn;
    logic            prev_clear, prev_inc, prev_dec, prev_load;
    logic            clr_e, inc_e, dec_e, ld_e;
    logic            lat_lvl, oth_lvl, abort, tick;
    logic            inc_req, dec_req;
    logic [HW-1:0]   hold_lim;

    assign clr_e   = btn_clear & ~prev_clear;
    assign inc_e   = btn_inc & ~prev_inc;
    assign dec_e   = btn_dec & ~prev_dec;
    assign ld_e    = btn_load & ~prev_load;
    assign lat_lvl = dir_dn ? btn_dec : btn_inc;
    assign oth_lvl = dir_dn ? btn_inc : btn_dec;
    assign hold_lim = (state == S_WAIT) ? HW'(REPEAT_DELAY - 1)
                                        : HW'(REPEAT_RATE - 1);

    always_comb begin
        inc_req = 1'b0;
        dec_req = 1'b0;
        abort   = 1'b0;
        tick    = 1'b0;
        unique case (state)
            S_IDLE: begin
                inc_req = inc_e;
                dec_req = dec_e;
            end
            S_WAIT, S_REPEAT: begin
                abort   = ~lat_lvl | oth_lvl | clr_e | ld_e;
                tick    = ~abort && (hold == hold_lim);
                inc_req = tick & ~dir_dn;
                dec_req = tick & dir_dn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            count      <= '0;
            limit_hit  <= 1'b0;
            state      <= S_IDLE;
            hold       <= '0;
            dir_dn     <= 1'b0;
            prev_clear <= 1'b0;
            prev_inc   <= 1'b0;
            prev_dec   <= 1'b0;
            prev_load  <= 1'b0;
        end else begin
            prev_clear <= btn_clear;
            prev_inc   <= btn_inc;
            prev_dec   <= btn_dec;
            prev_load  <= btn_load;
            limit_hit  <= 1'b0;

            if (clr_e) begin
                count <= '0;
            end else if (ld_e) begin
                count <= load_value;
            end else if (inc_req && dec_req) begin
                count <= count;
            end else if (inc_req) begin
                if (count == MAXV) begin
                    limit_hit <= 1'b1;
                    count     <= (SATURATE != 0) ? MAXV : '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (dec_req) begin
                if (count == '0) begin
                    limit_hit <= 1'b1;
                    count     <= (SATURATE != 0) ? '0 : MAXV;
                end else begin
                    count <= count - 1'b1;
                end
            end

            // Repeat only starts from a lone step edge that actually stepped.
            unique case (state)
                S_IDLE: begin
                    if ((btn_inc ^ btn_dec) && (inc_e || dec_e) &&
                        !clr_e && !ld_e) begin
                        state  <= S_WAIT;
                        hold   <= '0;
                        dir_dn <= btn_dec;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        state <= S_REPEAT;
                        hold  <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        hold <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [RW-1:0] refresh;
    logic [1:0]    digit, digit_nxt;
    logic          term;
    logic [15:0]   cnt16;
    logic [3:0]    nib;

    assign term      = (refresh == RW'(REFRESH_DIV - 1));
    assign digit_nxt = term ? digit + 2'd1 : digit;
    assign cnt16     = 16'(count);

    always_comb begin
        unique case (digit_nxt)
            2'd0:    nib = cnt16[3:0];
            2'd1:    nib = cnt16[7:4];
            2'd2:    nib = cnt16[11:8];
            default: nib = cnt16[15:12];
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            refresh <= '0;
            digit   <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else begin
            refresh <= term ? '0 : refresh + 1'b1;
            digit   <= digit_nxt;
            an      <= ~(4'b0001 << digit_nxt);
            seg     <= hex7(nib);
        end
    end

endmodule
